// File: rtl/pps_skew_pkg.sv
// pps_skew_pkg: shared FSM state, offset width and statistics reset constants for pps_skew_monitor.
package pps_skew_pkg;

    typedef enum logic [1:0] {IDLE, WAIT_SLAVE, WAIT_MASTER} state_e;

    localparam int OFFSET_W = 16;

    localparam logic signed [OFFSET_W-1:0] STAT_MIN_RST = 16'sh7FFF;
    localparam logic signed [OFFSET_W-1:0] STAT_MAX_RST = 16'sh8000;

endpackage

// File: rtl/pps_edge_detect.sv
// pps_edge_detect: rising-edge detector for one PPS input; a level already high at reset release is ignored.
module pps_edge_detect (
    input  logic clk_i,
    input  logic rst_i,
    input  logic pps_i,
    output logic edge_o
);

    logic prev_q;
    logic armed_q;

    // armed_q holds off detection for the first cycle so prev_q can capture the level present at release
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            prev_q  <= 1'b0;
            armed_q <= 1'b0;
        end else begin
            prev_q  <= pps_i;
            armed_q <= 1'b1;
        end
    end

    assign edge_o = armed_q & pps_i & ~prev_q;

endmodule

// File: rtl/pps_skew_monitor.sv
// pps_skew_monitor: measures slave-minus-master PPS offset in clock cycles and tracks lock.
// Optional min/max/count statistics are built when PPS_SKEW_STATS_EN is defined.
module pps_skew_monitor
    import pps_skew_pkg::*;
#(
    parameter int G_WINDOW     = 1024,
    parameter int G_TOL        = 2,
    parameter int G_LOCK_COUNT = 3
) (
    input  logic                       clk_125m_i,
    input  logic                       rst_i,
    input  logic                       pps_master_i,
    input  logic                       pps_slave_i,
    output logic signed [OFFSET_W-1:0] offset_o,
    output logic                       offset_valid_o,
    output logic                       timeout_o,
    output logic                       miss_o,
    output logic                       locked_o
`ifdef PPS_SKEW_STATS_EN
    ,
    input  logic                       clear_stats_i,
    output logic signed [OFFSET_W-1:0] offset_min_o,
    output logic signed [OFFSET_W-1:0] offset_max_o,
    output logic        [OFFSET_W-1:0] meas_count_o
`endif
);

    localparam logic [15:0] WIN  = 16'(G_WINDOW);
    localparam logic [15:0] TOL  = 16'(G_TOL);
    localparam logic [7:0]  LOCK = 8'(G_LOCK_COUNT);

    logic                       m_edge, s_edge;
    state_e                     state_q, state_d;
    logic [15:0]                cnt_q, cnt_d;
    logic [7:0]                 good_q, good_d;
    logic signed [OFFSET_W-1:0] offset_q, offset_d;
    logic                       valid_q, valid_d;
    logic                       timeout_q, timeout_d;
    logic                       miss_q, miss_d;
    logic                       locked_q;
    logic [15:0]                mag;

    pps_edge_detect u_master_edge (.clk_i(clk_125m_i), .rst_i(rst_i), .pps_i(pps_master_i), .edge_o(m_edge));
    pps_edge_detect u_slave_edge  (.clk_i(clk_125m_i), .rst_i(rst_i), .pps_i(pps_slave_i),  .edge_o(s_edge));

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + 16'd1;
        offset_d  = offset_q;
        valid_d   = 1'b0;
        timeout_d = 1'b0;
        miss_d    = 1'b0;
        mag       = '0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (m_edge && s_edge) begin
                    offset_d = '0;
                    valid_d  = 1'b1;
                end else if (m_edge) begin
                    state_d = WAIT_SLAVE;
                    cnt_d   = 16'd1;
                end else if (s_edge) begin
                    state_d = WAIT_MASTER;
                    cnt_d   = 16'd1;
                end
            end
            WAIT_SLAVE: begin
                if (s_edge) begin
                    offset_d = $signed(cnt_q);
                    mag      = cnt_q;
                    valid_d  = 1'b1;
                    state_d  = IDLE;
                    cnt_d    = '0;
                end else if (m_edge) begin
                    miss_d = 1'b1;
                    cnt_d  = 16'd1;
                end else if (cnt_q == WIN) begin
                    timeout_d = 1'b1;
                    state_d   = IDLE;
                    cnt_d     = '0;
                end
            end
            WAIT_MASTER: begin
                if (m_edge) begin
                    offset_d = -$signed(cnt_q);
                    mag      = cnt_q;
                    valid_d  = 1'b1;
                    state_d  = IDLE;
                    cnt_d    = '0;
                end else if (s_edge) begin
                    miss_d = 1'b1;
                    cnt_d  = 16'd1;
                end else if (cnt_q == WIN) begin
                    timeout_d = 1'b1;
                    state_d   = IDLE;
                    cnt_d     = '0;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
        good_d = good_q;
        if (valid_d && mag <= TOL)
            good_d = (good_q == LOCK) ? good_q : good_q + 8'd1;
        else if (valid_d || timeout_d || miss_d)
            good_d = '0;
    end

    always_ff @(posedge clk_125m_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            good_q    <= '0;
            offset_q  <= '0;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
            miss_q    <= 1'b0;
            locked_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            good_q    <= good_d;
            offset_q  <= offset_d;
            valid_q   <= valid_d;
            timeout_q <= timeout_d;
            miss_q    <= miss_d;
            locked_q  <= (good_d == LOCK);
        end
    end

    assign offset_o       = offset_q;
    assign offset_valid_o = valid_q;
    assign timeout_o      = timeout_q;
    assign miss_o         = miss_q;
    assign locked_o       = locked_q;

`ifdef PPS_SKEW_STATS_EN
    logic signed [OFFSET_W-1:0] min_q, min_d;
    logic signed [OFFSET_W-1:0] max_q, max_d;
    logic [OFFSET_W-1:0]        mcnt_q, mcnt_d;

    always_comb begin
        min_d  = min_q;
        max_d  = max_q;
        mcnt_d = mcnt_q;
        if (clear_stats_i) begin
            min_d  = STAT_MIN_RST;
            max_d  = STAT_MAX_RST;
            mcnt_d = '0;
        end else if (valid_d) begin
            min_d  = (offset_d < min_q) ? offset_d : min_q;
            max_d  = (offset_d > max_q) ? offset_d : max_q;
            mcnt_d = (mcnt_q == 16'hFFFF) ? mcnt_q : mcnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk_125m_i or posedge rst_i) begin
        if (rst_i) begin
            min_q  <= STAT_MIN_RST;
            max_q  <= STAT_MAX_RST;
            mcnt_q <= '0;
        end else begin
            min_q  <= min_d;
            max_q  <= max_d;
            mcnt_q <= mcnt_d;
        end
    end

    assign offset_min_o = min_q;
    assign offset_max_o = max_q;
    assign meas_count_o = mcnt_q;
`endif

endmodule
